// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
//   arb_state_t : RUN (normal arbitration), LOCK (loader exclusive), DRAIN (no grants)
//   owner_t     : which requester owns the read response in flight
//   resp_tag_t  : registered response tag (owner + bad-access flag)
package imem_arb_pkg;

  localparam int unsigned IMEM_ADDR_W   = 32;
  localparam int unsigned IMEM_DEPTH_W  = 10;
  localparam int unsigned IMEM_MAX_WAIT = 4;
  localparam int unsigned IMEM_DATA_W   = 32;

  // RISC-V NOP, reserved for later use (e.g. a flush bubble).
  localparam logic [IMEM_DATA_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOCK  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LD    = 2'd2
  } owner_t;

  typedef struct packed {
    owner_t owner;
    logic   bad;
  } resp_tag_t;

endpackage

// File: rtl/imem_addr_check.sv
// Combinational byte-address decode for one requester.
//   addr  : requester byte address
//   idx_c : IMEM word index, addr[DEPTH_W+1:2]
//   bad_c : misaligned or beyond the IMEM word count
module imem_addr_check
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = IMEM_ADDR_W,
  parameter int unsigned DEPTH_W = IMEM_DEPTH_W
) (
  input  logic [ADDR_W-1:0]  addr,
  output logic [DEPTH_W-1:0] idx_c,
  output logic               bad_c
);

  logic out_of_range;

  assign idx_c = addr[DEPTH_W+1:2];

  // Any set bit above the word-index field lies past the end of IMEM.
  generate
    if (ADDR_W > DEPTH_W + 2) begin : g_range
      assign out_of_range = |addr[ADDR_W-1:DEPTH_W+2];
    end else begin : g_no_range
      assign out_of_range = 1'b0;
    end
  endgenerate

  assign bad_c = (addr[1:0] != 2'b00) || out_of_range;

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous IMEM port between CPU fetch (read-only) and the
// program loader (read/write). Fetch has priority; a loader that has waited
// MAX_WAIT consecutive cycles is forced through. ld_lock gives the loader
// exclusive access (LOCK), followed by one DRAIN cycle with no grants.
// Optional macro IMEM_ARB_PERF_EN adds perf_fetch_stall (saturating count of
// cycles where fetch requested but was not granted).
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   fetch_req/addr -> fetch_gnt       fetch request and combinational grant
//   fetch_rvalid/rdata/err            fetch read response, one cycle after grant
//   ld_req/we/addr/wdata/lock         loader request, write enable, lock request
//   ld_gnt, ld_rvalid/rdata/err       loader grant and read response
//   locked                            FSM is in LOCK
//   mem_en/we/addr/wdata, mem_rdata   IMEM port (rdata valid the cycle after a read)
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = IMEM_ADDR_W,
  parameter int unsigned DEPTH_W  = IMEM_DEPTH_W,
  parameter int unsigned MAX_WAIT = IMEM_MAX_WAIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic               fetch_gnt,
  output logic               fetch_rvalid,
  output logic [31:0]        fetch_rdata,
  output logic               fetch_err,
  input  logic               ld_req,
  input  logic               ld_we,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic [31:0]        ld_wdata,
  input  logic               ld_lock,
  output logic               ld_gnt,
  output logic               ld_rvalid,
  output logic [31:0]        ld_rdata,
  output logic               ld_err,
  output logic               locked,
  output logic               mem_en,
  output logic               mem_we,
  output logic [DEPTH_W-1:0] mem_addr,
  output logic [31:0]        mem_wdata,
  input  logic [31:0]        mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [15:0]        perf_fetch_stall
`endif
);

  localparam int unsigned WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  arb_state_t         state_q;
  logic [WAIT_W-1:0]  wait_q;
  resp_tag_t          tag_q;
  resp_tag_t          tag_d;

  logic [DEPTH_W-1:0] fetch_idx;
  logic [DEPTH_W-1:0] ld_idx;
  logic               fetch_bad;
  logic               ld_bad;
  logic               fetch_good;
  logic               ld_good;

  imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) u_fetch_chk (
    .addr  (fetch_addr),
    .idx_c (fetch_idx),
    .bad_c (fetch_bad)
  );

  imem_addr_check #(.ADDR_W(ADDR_W), .DEPTH_W(DEPTH_W)) u_ld_chk (
    .addr  (ld_addr),
    .idx_c (ld_idx),
    .bad_c (ld_bad)
  );

  // Grant decision; nothing is granted while reset is held.
  always_comb begin
    fetch_gnt = 1'b0;
    ld_gnt    = 1'b0;
    if (rst_n) begin
      case (state_q)
        RUN: begin
          if (ld_req && (wait_q == WAIT_W'(MAX_WAIT))) begin
            ld_gnt = 1'b1;
          end else if (fetch_req) begin
            fetch_gnt = 1'b1;
          end else if (ld_req) begin
            ld_gnt = 1'b1;
          end
        end
        LOCK:    ld_gnt = ld_req;
        default: ;
      endcase
    end
  end

  // Memory strobe; bad accesses are granted but never reach the array.
  always_comb begin
    fetch_good = fetch_gnt && !fetch_bad;
    ld_good    = ld_gnt && !ld_bad;
    mem_en     = fetch_good || ld_good;
    mem_we     = ld_good && ld_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (ld_good) begin
      mem_addr = ld_idx;
      if (ld_we) mem_wdata = ld_wdata;
    end else if (fetch_good) begin
      mem_addr = fetch_idx;
    end
  end

  // Tag for next cycle's read response; writes produce none.
  always_comb begin
    tag_d = '{owner: OWN_NONE, bad: 1'b0};
    if (fetch_gnt) begin
      tag_d = '{owner: OWN_FETCH, bad: fetch_bad};
    end else if (ld_gnt && !ld_we) begin
      tag_d = '{owner: OWN_LD, bad: ld_bad};
    end
  end

  // FSM, loader aging counter and response tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= '0;
      tag_q   <= '{owner: OWN_NONE, bad: 1'b0};
    end else begin
      tag_q <= tag_d;

      if (ld_req && !ld_gnt) begin
        if (wait_q != WAIT_W'(MAX_WAIT)) wait_q <= wait_q + WAIT_W'(1);
      end else begin
        wait_q <= '0;
      end

      case (state_q)
        // Entering LOCK waits for any fetch response still in flight.
        RUN:     if (ld_lock && (tag_q.owner != OWN_FETCH)) state_q <= LOCK;
        LOCK:    if (!ld_lock) state_q <= DRAIN;
        DRAIN:   state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

  assign locked       = (state_q == LOCK);
  assign fetch_rvalid = (tag_q.owner == OWN_FETCH);
  assign ld_rvalid    = (tag_q.owner == OWN_LD);
  assign fetch_err    = fetch_rvalid && tag_q.bad;
  assign fetch_rdata  = (fetch_rvalid && !tag_q.bad) ? mem_rdata : 32'h0;
  assign ld_rdata     = (ld_rvalid && !tag_q.bad) ? mem_rdata : 32'h0;
  // Bad reads flag with the response; bad writes flag in the grant cycle.
  assign ld_err       = (ld_rvalid && tag_q.bad) || (ld_gnt && ld_we && ld_bad);

`ifdef IMEM_ARB_PERF_EN
  // Saturating count of cycles fetch asked and was refused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_stall <= 16'h0;
    end else if (fetch_req && !fetch_gnt && (perf_fetch_stall != 16'hFFFF)) begin
      perf_fetch_stall <= perf_fetch_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: directed stimulus, a transaction-level model
// of the arbitration rules and memory contents, and a per-cycle compare.
// Honors IMEM_ARB_PERF_EN when defined.
module tb_imem_port_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int S_RUN = 0, S_LOCK = 1, S_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_gnt, fetch_rvalid, fetch_err;
  logic [31:0] fetch_rdata;
  logic        ld_req = 1'b0, ld_we = 1'b0, ld_lock = 1'b0;
  logic [31:0] ld_addr = 32'h0, ld_wdata = 32'h0;
  logic        ld_gnt, ld_rvalid, ld_err, locked;
  logic [31:0] ld_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef IMEM_ARB_PERF_EN
  logic [15:0] perf_fetch_stall;
`endif

  imem_port_arbiter #(.ADDR_W(32), .DEPTH_W(10), .MAX_WAIT(MAX_WAIT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_gnt    (fetch_gnt),
    .fetch_rvalid (fetch_rvalid),
    .fetch_rdata  (fetch_rdata),
    .fetch_err    (fetch_err),
    .ld_req       (ld_req),
    .ld_we        (ld_we),
    .ld_addr      (ld_addr),
    .ld_wdata     (ld_wdata),
    .ld_lock      (ld_lock),
    .ld_gnt       (ld_gnt),
    .ld_rvalid    (ld_rvalid),
    .ld_rdata     (ld_rdata),
    .ld_err       (ld_err),
    .locked       (locked),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
`ifdef IMEM_ARB_PERF_EN
    ,
    .perf_fetch_stall (perf_fetch_stall)
`endif
  );

  always #5 clk = ~clk;

  // Synchronous IMEM array seen by the DUT.
  logic [31:0] ram [0:1023];
  logic [31:0] rd_q = 32'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        rd_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = rd_q;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'h0000_1000);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'(a[11:2]);
  endfunction

  // Model state: arbitration mode, loader wait age, pending read response, memory image.
  int          m_state, m_wait, m_perf;
  bit          r_v, r_f, r_bad;
  logic [31:0] r_d;
  logic [31:0] m_mem [0:1023];
  int          n_state, n_wait, n_perf, n_widx;
  bit          n_v, n_f, n_bad, n_wr;
  logic [31:0] n_d, n_wd;

  task automatic m_reset();
    m_state = S_RUN; m_wait = 0; m_perf = 0;
    r_v = 1'b0; r_f = 1'b0; r_bad = 1'b0; r_d = 32'h0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reset();
    end else begin
      m_state = n_state; m_wait = n_wait; m_perf = n_perf;
      r_v = n_v; r_f = n_f; r_bad = n_bad; r_d = n_d;
      if (n_wr) m_mem[n_widx] = n_wd;
    end
  end

  // Per-cycle compare against the model, then compute the model's next step.
  always @(negedge clk) begin : cmp
    bit fb, lb, eg_f, eg_l, e_en, e_wr, e_rvf, e_rvl;
    int e_idx;
    fb = is_bad(fetch_addr);
    lb = is_bad(ld_addr);
    eg_f = 1'b0;
    eg_l = 1'b0;
    if (rst_n) begin
      if (m_state == S_RUN) begin
        if (ld_req && m_wait == MAX_WAIT) eg_l = 1'b1;
        else if (fetch_req)               eg_f = 1'b1;
        else if (ld_req)                  eg_l = 1'b1;
      end else if (m_state == S_LOCK) begin
        eg_l = ld_req;
      end
    end
    e_en  = (eg_f && !fb) || (eg_l && !lb);
    e_wr  = eg_l && ld_we && !lb;
    e_idx = eg_l ? word_of(ld_addr) : word_of(fetch_addr);
    e_rvf = r_v && r_f;
    e_rvl = r_v && !r_f;

    chk("fetch_gnt", 32'(fetch_gnt), 32'(eg_f));
    chk("ld_gnt", 32'(ld_gnt), 32'(eg_l));
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_wr));
    if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_idx));
    if (e_wr) chk("mem_wdata", mem_wdata, ld_wdata);
    chk("locked", 32'(locked), 32'(m_state == S_LOCK));
    chk("fetch_rvalid", 32'(fetch_rvalid), 32'(e_rvf));
    chk("ld_rvalid", 32'(ld_rvalid), 32'(e_rvl));
    chk("fetch_err", 32'(fetch_err), 32'(e_rvf && r_bad));
    chk("ld_err", 32'(ld_err), 32'((e_rvl && r_bad) || (eg_l && ld_we && lb)));
    if (e_rvf || !rst_n) chk("fetch_rdata", fetch_rdata, e_rvf ? r_d : 32'h0);
    if (e_rvl || !rst_n) chk("ld_rdata", ld_rdata, e_rvl ? r_d : 32'h0);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_fetch_stall", 32'(perf_fetch_stall), 32'(m_perf));
`endif

    n_v    = eg_f || (eg_l && !ld_we);
    n_f    = eg_f;
    n_bad  = eg_f ? fb : lb;
    n_d    = n_bad ? 32'h0 : m_mem[e_idx];
    n_wait = (ld_req && !eg_l) ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
    case (m_state)
      S_RUN:   n_state = (ld_lock && !e_rvf) ? S_LOCK : S_RUN;
      S_LOCK:  n_state = ld_lock ? S_LOCK : S_DRAIN;
      default: n_state = S_RUN;
    endcase
    n_perf = (fetch_req && !eg_f && m_perf < 65535) ? m_perf + 1 : m_perf;
    n_wr   = e_wr;
    n_widx = e_idx;
    n_wd   = ld_wdata;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int got;
    int perf0;
    got = 0;
    perf0 = 0;
    m_reset();
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = 32'hC0DE_0000 | 32'(i);
      if (i == 0) w = 32'h0020_8233;
      if (i == 1) w = 32'h4020_82b3;
      if (i == 2) w = 32'h0011_1333;
      ram[i] <= w;
      m_mem[i] = w;
    end

    #1 rst_n = 1'b0;
    smp();
    smp();
    chk("rst_fetch_rvalid", 32'(fetch_rvalid), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Back-to-back fetches: a response every cycle, no bubble.
    cyc(); fetch_req = 1'b1; fetch_addr = 32'h0;
    smp(); chk("f0_gnt", 32'(fetch_gnt), 32'h1);
    cyc(); fetch_addr = 32'h4;
    smp(); chk("f0_rdata", fetch_rdata, 32'h0020_8233); chk("f0_rvalid", 32'(fetch_rvalid), 32'h1);
    cyc(); fetch_addr = 32'h8;
    smp(); chk("f1_rdata", fetch_rdata, 32'h4020_82b3);
    cyc(); fetch_req = 1'b0;
    smp(); chk("f2_rdata", fetch_rdata, 32'h0011_1333);

    // Aging: loader forced through on its 5th waiting cycle.
    cyc(); fetch_req = 1'b1; fetch_addr = 32'hC; ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h10;
    for (int i = 1; i <= 10; i++) begin
      smp();
      if (ld_gnt) begin
        got = i;
        break;
      end
      cyc();
    end
    chk("age_grant_cycle", 32'(got), 32'd5);
    cyc(); ld_req = 1'b0;
    smp(); chk("age_fetch_regrant", 32'(fetch_gnt), 32'h1); chk("age_ld_rdata", ld_rdata, 32'hC0DE_0004);
    cyc(); fetch_req = 1'b0;
    smp();

    // Lock, loader write, drain.
    cyc(); ld_lock = 1'b1;
    smp(); chk("lock_not_yet", 32'(locked), 32'h0);
    cyc(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'd20; ld_wdata = 32'h0020_c4b3;
    smp(); chk("lock_locked", 32'(locked), 32'h1); chk("lock_mem_addr", 32'(mem_addr), 32'd5);
    chk("lock_mem_we", 32'(mem_we), 32'h1);
`ifdef IMEM_ARB_PERF_EN
    perf0 = int'(perf_fetch_stall);
`endif
    cyc(); ld_req = 1'b0; ld_we = 1'b0; fetch_req = 1'b1; fetch_addr = 32'd20;
    smp(); chk("lock_fetch_blocked", 32'(fetch_gnt), 32'h0);
    cyc(); smp();
    cyc(); ld_lock = 1'b0;
    smp(); chk("lock_last", 32'(locked), 32'h1);
    cyc(); smp(); chk("drain_no_gnt", 32'(fetch_gnt), 32'h0); chk("drain_unlocked", 32'(locked), 32'h0);
    cyc(); smp(); chk("run_fetch_regrant", 32'(fetch_gnt), 32'h1);
`ifdef IMEM_ARB_PERF_EN
    chk("perf_lock_stalls", 32'(perf_fetch_stall), 32'(perf0 + 4));
`endif
    cyc(); fetch_req = 1'b0;
    smp(); chk("lock_written_word", fetch_rdata, 32'h0020_c4b3);

    // Bad fetch addresses: misaligned and out of range.
    cyc(); fetch_req = 1'b1; fetch_addr = 32'h6;
    smp(); chk("bad_f_gnt", 32'(fetch_gnt), 32'h1); chk("bad_f_mem_en", 32'(mem_en), 32'h0);
    cyc(); fetch_addr = 32'h1000;
    smp(); chk("bad_f0_err", 32'(fetch_err), 32'h1); chk("bad_f0_rdata", fetch_rdata, 32'h0);
    cyc(); fetch_req = 1'b0;
    smp(); chk("bad_f1_err", 32'(fetch_err), 32'h1); chk("bad_f1_rvalid", 32'(fetch_rvalid), 32'h1);

    // Bad loader write, then bad loader read.
    cyc(); ld_req = 1'b1; ld_we = 1'b1; ld_addr = 32'h1004; ld_wdata = 32'hDEAD_BEEF;
    smp(); chk("bad_w_err", 32'(ld_err), 32'h1); chk("bad_w_mem_en", 32'(mem_en), 32'h0);
    cyc(); ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h2;
    smp(); chk("bad_r_gnt_err", 32'(ld_err), 32'h0);
    cyc(); ld_req = 1'b0;
    smp(); chk("bad_r_err", 32'(ld_err), 32'h1); chk("bad_r_rdata", ld_rdata, 32'h0);

    // Reset while a fetch read is in flight.
    cyc(); fetch_req = 1'b1; fetch_addr = 32'h4;
    smp(); chk("rst_mid_gnt", 32'(fetch_gnt), 32'h1);
    #2 rst_n = 1'b0; fetch_req = 1'b0;
    smp(); chk("rst_mid_rvalid", 32'(fetch_rvalid), 32'h0); chk("rst_mid_rdata", fetch_rdata, 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    smp(); chk("rst_after_rvalid", 32'(fetch_rvalid), 32'h0);
    smp();
    smp();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares the single synchronous instruction-memory port between two requesters:
  - CPU fetch: read-only.
  - Program loader/debug: read or write.
- Fixed priority to fetch, with an aging override so the loader cannot starve.
- A lock mode gives the loader exclusive access while a program image is written.
- Sits between the fetch stage/loader and the IMEM array; one access per cycle, 1-cycle read latency.

Parameters:
- ADDR_W, 32, byte-address width of both requesters.
- DEPTH_W, 10, log2 of the IMEM word count (1024 words).
- MAX_WAIT, 4, consecutive loader wait cycles before the loader is forced a grant.

Ports:
- clk  in  1  single clock; all state on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req  in  1  fetch read request; held until granted.
- fetch_addr  in  ADDR_W  fetch byte address.
- fetch_gnt  out  1  request accepted this cycle (combinational).
- fetch_rvalid  out  1  fetch read data valid.
- fetch_rdata  out  32  fetched instruction.
- fetch_err  out  1  with rvalid: misaligned or out-of-range access.
- ld_req  in  1  loader request; held until granted.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  ADDR_W  loader byte address.
- ld_wdata  in  32  loader write data.
- ld_lock  in  1  request exclusive access.
- ld_gnt  out  1  loader request accepted (combinational).
- ld_rvalid  out  1  loader read data valid.
- ld_rdata  out  32  loader read data.
- ld_err  out  1  with rvalid or gnt: bad access.
- locked  out  1  FSM is in LOCK.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write.
- mem_addr  out  DEPTH_W  word index = addr[DEPTH_W+1:2].
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset: all outputs 0; FSM = RUN; wait counter 0; response-owner register = NONE.
- FSM states:
  - RUN → LOCK when ld_lock=1 and no fetch read is in flight, i.e. owner ≠ FETCH.
  - LOCK → DRAIN when ld_lock=0.
  - DRAIN → RUN after one cycle, which lets the last loader read respond.
- Arbitration in RUN:
  - Loader wins if wait_cnt == MAX_WAIT, else fetch wins if fetch_req, else loader.
  - Exactly one gnt per cycle, at most.
- Arbitration in LOCK: fetch_gnt = 0 always; ld_gnt = ld_req.
- Arbitration in DRAIN: no grants.
- wait_cnt:
  - Increments, saturating at MAX_WAIT, when ld_req=1 and ld_gnt=0.
  - Clears on ld_gnt or when ld_req=0.
- Bad access: addr[1:0] ≠ 0, or addr ≥ 4·2^DEPTH_W.
  - Still granted, but mem_en = 0.
  - A read returns rdata = 0 and err = 1 next cycle.
  - A write is dropped, with ld_err = 1 in the grant cycle.
- Good grant: mem_en = 1; mem_we = ld_we for the loader, 0 for fetch.
- Read response:
  - The owner of a read granted at cycle N gets rvalid = 1 at N+1.
  - rdata = mem_rdata, registered pass-through of the owner tag.
- Writes produce no rvalid.
- Responses are pipelined: back-to-back grants give back-to-back rvalids with no bubble.
- Reset asserted mid-access: in-flight responses are discarded and no rvalid is issued after release.
- ld_lock asserted while the FSM is in DRAIN: takes effect after DRAIN completes.

Optional Feature:
- IMEM_ARB_PERF_EN defined:
  - Adds output perf_fetch_stall [15:0].
  - Counts cycles with fetch_req=1 and fetch_gnt=0; saturates at 0xFFFF; cleared by reset.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Package imem_arb_pkg:
  - typedef enum {RUN, LOCK, DRAIN} arb_state_t.
  - typedef enum {OWN_NONE, OWN_FETCH, OWN_LD} owner_t.
  - NOP constant 32'h00000013, reserved for later use.
- One sub-module, imem_addr_check: combinational decode returning word index and bad flag; instantiated once per requester.

Test Plan:
- Reset then fetch_req with addr 0,4,8 consecutively; mem_rdata = 0x00208233, 0x402082b3, 0x00111333 → fetch_gnt every cycle; fetch_rvalid one cycle later with matching data, no bubbles.
- fetch_req and ld_req (read, addr 0x10) both held continuously → loader granted exactly on the 5th cycle; wait_cnt resets; fetch regranted next cycle.
- Assert ld_lock; loader writes 0x0020c4b3 to addr 20 → locked=1 next cycle; fetch_gnt=0 throughout; mem_we=1, mem_addr=5.
- Drop ld_lock → one DRAIN cycle with no grants, then RUN and fetch regranted.
- fetch_addr 0x6 and fetch_addr 0x1000 (DEPTH_W=10) → granted, mem_en=0, fetch_rvalid=1, fetch_rdata=0, fetch_err=1.
- Loader write to 0x1004 → ld_err=1 in the grant cycle; no mem write.
- rst_n pulsed low while a fetch read is in flight → no fetch_rvalid after release; all outputs 0.
- With IMEM_ARB_PERF_EN and a 3-cycle lock while fetch_req=1 → perf_fetch_stall increments by the number of stalled cycles (3 lock + 1 drain = 4).
